// File: rtl/palette_loader.sv
// Palette loader: captures a host .pal byte stream into a 64 x 15-bit palette RAM that is
// shared with the video colour lookup; video reads always win, loader writes are deferred.
module palette_loader #(
    parameter int ENTRIES = 64,
    parameter int CW      = 5,
    localparam int AW     = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            dl_en,
    input  logic            dl_wr,
    input  logic [7:0]      dl_data,
    output logic            dl_wait,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [3*CW-1:0] rd_data,
    output logic            pal_valid,
    output logic            busy
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(ENTRIES);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_e;

    state_e r_state, w_state_nxt;

    logic              r_dl_en_prev;
    logic [1:0]        r_phase;
    logic [AW:0]       r_idx;
    logic [AW:0]       r_cnt;
    logic [CW-1:0]     r_r;
    logic [CW-1:0]     r_g;
    logic              r_pending;
    logic [AW-1:0]     r_wb_addr;
    logic [3*CW-1:0]   r_wb_data;
    logic              r_proto_err;
    logic              r_pal_valid;
    logic              w_pal_valid_nxt;
    logic [3*CW-1:0]   r_rd_data;
    logic [3*CW-1:0]   r_ram [ENTRIES];

    logic w_dl_rise;
    logic w_wait;
    logic w_byte_ok;
    logic w_accept;
    logic w_proto_err;
    logic w_commit;
    logic w_load_done;
    logic w_unused;

    assign w_dl_rise   = dl_en & ~r_dl_en_prev;
    assign w_wait      = r_pending & (r_phase == 2'd2);
    // Bytes past the last entry are discarded even while the final write is still draining.
    assign w_byte_ok   = (r_state == StLoad) & dl_en & dl_wr & ~w_dl_rise & (r_idx != FULL_CNT);
    assign w_accept    = w_byte_ok & ~w_wait;
    assign w_proto_err = w_byte_ok & w_wait;
    assign w_commit    = r_pending & ~rd_en;
    assign w_load_done = ~r_pending & (r_cnt == FULL_CNT);

    assign dl_wait   = w_wait;
    assign busy      = (r_state != StIdle);
    assign pal_valid = r_pal_valid;
    assign rd_data   = r_rd_data;

    assign w_unused = ^{dl_data[7-CW:0], r_proto_err};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_pal_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pal_valid <= w_pal_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pal_valid_nxt = r_pal_valid;
        if (w_dl_rise) begin
            w_state_nxt     = StLoad;
            w_pal_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    w_state_nxt = StIdle;
                end
                StLoad: begin
                    if (w_load_done) begin
                        w_state_nxt     = StDone;
                        w_pal_valid_nxt = 1'b1;
                    end else if (!dl_en) begin
                        w_state_nxt     = StIdle;
                        w_pal_valid_nxt = 1'b0;
                    end
                end
                StDone: begin
                    if (!dl_en) begin
                        w_state_nxt = StIdle;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dl_en_prev <= 1'b0;
            r_phase      <= 2'd0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_r          <= '0;
            r_g          <= '0;
            r_pending    <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_dl_en_prev <= dl_en;
            if (w_dl_rise) begin
                r_phase     <= 2'd0;
                r_idx       <= '0;
                r_cnt       <= '0;
                r_pending   <= 1'b0;
                r_proto_err <= 1'b0;
            end else begin
                if (w_commit) begin
                    r_pending <= 1'b0;
                    r_cnt     <= r_cnt + (AW+1)'(1);
                end
                if (w_proto_err) begin
                    r_proto_err <= 1'b1;
                end
                // A blue byte is never accepted while pending, so this cannot race the commit.
                if (w_accept) begin
                    case (r_phase)
                        2'd0: begin
                            r_r     <= dl_data[7 -: CW];
                            r_phase <= 2'd1;
                        end
                        2'd1: begin
                            r_g     <= dl_data[7 -: CW];
                            r_phase <= 2'd2;
                        end
                        default: begin
                            r_wb_data <= {dl_data[7 -: CW], r_g, r_r};
                            r_wb_addr <= r_idx[AW-1:0];
                            r_pending <= 1'b1;
                            r_phase   <= 2'd0;
                            r_idx     <= r_idx + (AW+1)'(1);
                        end
                    endcase
                end
            end
        end
    end

    // Palette storage is deliberately not reset; only the loader's write port touches it.
    always_ff @(posedge clk) begin
        if (reset_n && w_commit) begin
            r_ram[r_wb_addr] <= r_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_ram[rd_addr];
        end
    end

endmodule

// File: doc/palette_loader.md
Name: palette_loader

Overview:
- Owns a 64-entry x 15-bit custom palette RAM for the NES video path.
- Loads the RAM from a host byte stream (a .pal file of 64 RGB triplets, 8 bits per channel).
- Shares the RAM between the video pixel lookup (read port, always wins) and the loader (write port, deferred).
- Video selects this palette when `pal_valid`=1; otherwise video falls back to its built-in LUTs.

Parameters:
- ENTRIES, 64, number of palette entries; index width = 6.
- CW, 5, output bits per colour channel; the top CW bits of each 8-bit byte are kept.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous active-low reset.
- `dl_en`  in  1  download window active; rising edge starts a new load.
- `dl_wr`  in  1  one-cycle byte strobe, valid only while `dl_en`=1.
- `dl_data`  in  8  download byte.
- `dl_wait`  out  1  host must hold off the next `dl_wr` while 1.
- `rd_en`  in  1  video read strobe (the pixel clock-enable cycle).
- `rd_addr`  in  6  NES colour index.
- `rd_data`  out  15  {B[4:0],G[4:0],R[4:0]}, registered.
- `pal_valid`  out  1  a complete 64-entry palette has been loaded.
- `busy`  out  1  FSM is not IDLE.

Behaviour:
- Reset values (applied when `reset_n`=0 on a `clk` edge): state=IDLE, `rd_data`=0, `pal_valid`=0, `dl_wait`=0, `busy`=0, byte phase=0, entry index=0, pending write cleared. RAM contents are not reset.
- Reset in the middle of a load abandons it; `pal_valid` stays 0.

FSM states IDLE, LOAD, DONE:
- IDLE -> LOAD on a `dl_en` rising edge. On entry: index=0, phase=0, pending cleared, `pal_valid`=0.
- LOAD, byte capture: each `dl_wr` stores `dl_data` into channel register R, G or B according to phase 0, 1 or 2, then phase increments.
- LOAD, entry complete: on the `dl_wr` with phase=2, the word {B[7:3],G[7:3],R[7:3]} is loaded into a one-entry write buffer at the current index. Pending is set, phase wraps to 0 and index increments.
- LOAD -> DONE when pending is clear and 64 entries have been committed. `pal_valid` is set in the same cycle.
- LOAD -> IDLE if `dl_en` falls before 64 entries are committed. `pal_valid`=0; entries already written remain in RAM.
- DONE -> IDLE when `dl_en` falls. `pal_valid` holds at 1.
- DONE: `dl_wr` strobes (bytes beyond 192) are ignored.
- A `dl_en` rising edge in any state restarts the load and clears `pal_valid`.

Arbitration:
- A pending write commits on the first cycle with `rd_en`=0.
- A cycle with `rd_en`=1 always performs the read; the write waits.
- `dl_wait` = pending AND (phase=2). The host may send the R and G bytes of the next entry while a write is pending, but not the B byte.
- A `dl_wr` arriving while `dl_wait`=1 is a protocol error. It is dropped and a sticky internal flag is set; the flag is cleared on restart.

Read:
- 1-cycle latency: `rd_data` is updated at the edge after the `rd_en` cycle with RAM[`rd_addr`] and holds between reads.
- Read during write (same cycle) cannot occur, because writes never share a cycle with `rd_en`.
- Reads are legal in every state. During LOAD they return a mix of old and new entries.

Widths: the channel truncation uses byte[7:8-CW]; no rounding.

Test Plan:
- Full load, rd_en=0 throughout: dl_en rises, 192 bytes with entry i = (8i, 4i, 2i), one byte per 2 cycles. Expect pal_valid=1 within 2 cycles of the last byte and busy=0 after dl_en falls. Read of addr 5 returns {5'd1,5'd2,5'd5}=15'h0445.
- Read priority: hold rd_en=1 continuously while entry 0 = (FF,00,00) completes. Expect dl_wait=1 once pending is set and the phase-2 byte is reached, and RAM untouched. Drop rd_en: write commits next cycle, dl_wait=0, and a subsequent read of addr 0 returns 15'h001F.
- Truncated load: dl_en falls after 100 bytes (33 entries + 1 byte). Expect state IDLE, pal_valid=0, entries 0..32 written, entry 33 unchanged.
- Overrun: 200 bytes. Expect bytes 193..200 ignored, pal_valid=1, entry 63 equal to bytes 190..192.
- Reset mid-load: reset_n=0 for 1 cycle after 60 bytes. Expect all outputs at reset values. A fresh 192-byte load then yields pal_valid=1.
- Reload: after a valid load, dl_en rises again. Expect pal_valid drops to 0 in the next cycle and returns to 1 after the second full load.
